// File: rtl/tea_stream_fifo_pkg.sv
// tea_stream_fifo shared definitions: register offsets,
// STATUS/CTRL bit positions and the upstream FSM encoding.
package tea_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_THR    = 2'd3;

  localparam int ST_EMPTY = 16;
  localparam int ST_FULL  = 17;
  localparam int ST_UDF   = 18;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_UDF_CLR = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } fsm_e;

endpackage

// File: rtl/tea_stream_fifo_if.sv
// Core result handshake plus the APB slave port of
// tea_stream_fifo, bundled for module ports.
interface tea_stream_fifo_if;

  logic        req;
  logic        ack;
  logic [31:0] rdata;

  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport slave (
    output req,
    input  ack,
    input  rdata,
    input  psel,
    input  penable,
    input  pwrite,
    input  paddr,
    input  pwdata,
    output prdata
  );

  modport master (
    input  req,
    output ack,
    output rdata,
    output psel,
    output penable,
    output pwrite,
    output paddr,
    output pwdata,
    input  prdata
  );

endinterface

// File: rtl/tea_stream_fifo_sync2.sv
// Generic two-flop synchroniser, used to bring the core's
// ack into the APB clock domain.
module tea_sync2 #(
  parameter int W = 1
) (
  input  logic         pclk,
  input  logic         prstb,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge pclk or negedge prstb) begin
    if (!prstb) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/tea_stream_fifo.sv
// Core result collector: req/ack puller, FIFO, APB drain.
// TEA_STREAM_FIFO_IRQ_EN adds the THR register and irq port.
module tea_stream_fifo
  import tea_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic              pclk,
  input logic              prstb,
  tea_stream_fifo_if.slave bus
`ifdef TEA_STREAM_FIFO_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic          ack_s;
  fsm_e          state_q;
  logic          req_q;
  logic          en_q;
  logic          udf_q;
  logic          rd_vld_q;
  logic [31:0]   prdata_q;
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] wptr_d;
  logic [AW-1:0] rptr_q;
  logic [AW-1:0] rptr_d;
  logic [AW:0]   level_q;
  logic [AW:0]   level_d;
  logic [31:0]   mem_q [DEPTH];

  logic        acc;
  logic        setup;
  logic        wr;
  logic        rd;
  logic [1:0]  sel;
  logic        is_data;
  logic        is_status;
  logic        is_ctrl;
  logic        is_thr;
  logic        push;
  logic        pop;
  logic        flush;
  logic        udf_set;
  logic        udf_clr;
  logic        empty;
  logic        full;
  logic [31:0] status_w;
  logic [31:0] thr_rd;
  logic [31:0] rd_word;
  logic        unused_bits;

  tea_sync2 #(.W(1)) u_ack_sync (
    .pclk  (pclk),
    .prstb (prstb),
    .d_i   (bus.ack),
    .q_o   (ack_s)
  );

  assign acc   = bus.psel & bus.penable;
  assign setup = bus.psel & ~bus.penable & ~bus.pwrite;
  assign wr    = acc & bus.pwrite;
  assign rd    = acc & ~bus.pwrite;
  assign sel   = bus.paddr[3:2];

  assign is_data   = (sel == REG_DATA);
  assign is_status = (sel == REG_STATUS);
  assign is_ctrl   = (sel == REG_CTRL);
  assign is_thr    = (sel == REG_THR);

  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_FULL);

  assign flush   = wr & is_ctrl & bus.pwdata[CTRL_FLUSH];
  assign udf_clr = wr & is_ctrl & bus.pwdata[CTRL_UDF_CLR];
  // pop/udf follow the emptiness seen when prdata was captured
  assign pop     = rd & is_data & rd_vld_q;
  assign udf_set = rd & is_data & ~rd_vld_q;
  assign push    = (state_q == REQ) & ack_s & ~flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge pclk or negedge prstb) begin
    if (!prstb) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge pclk) begin
    if (push) mem_q[wptr_q] <= bus.rdata;
  end

  // the slot is reserved on entering REQ; only pops follow
  always_ff @(posedge pclk or negedge prstb) begin
    if (!prstb) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (en_q && !full && !ack_s) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        REQ: begin
          if (ack_s) begin
            state_q <= DONE;
            req_q   <= 1'b0;
          end
        end
        DONE: begin
          if (!ack_s) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge pclk or negedge prstb) begin
    if (!prstb) begin
      en_q  <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr && is_ctrl) en_q <= bus.pwdata[CTRL_EN];
      if (udf_set)       udf_q <= 1'b1;
      else if (udf_clr)  udf_q <= 1'b0;
    end
  end

`ifdef TEA_STREAM_FIFO_IRQ_EN
  logic [AW:0] thr_q;
  logic        irq_q;

  always_ff @(posedge pclk or negedge prstb) begin
    if (!prstb) begin
      thr_q <= '0;
      irq_q <= 1'b0;
    end else begin
      if (wr && is_thr) thr_q <= bus.pwdata[AW:0];
      irq_q <= (thr_q != '0) && (level_q >= thr_q);
    end
  end

  assign thr_rd = 32'(thr_q);
  assign irq    = irq_q;
`else
  assign thr_rd = '0;
`endif

  always_comb begin
    status_w           = '0;
    status_w[AW:0]     = level_q;
    status_w[ST_EMPTY] = empty;
    status_w[ST_FULL]  = full;
    status_w[ST_UDF]   = udf_q;
  end

  always_comb begin
    rd_word = '0;
    unique case (1'b1)
      is_data:   rd_word = empty ? '0 : mem_q[rptr_q];
      is_status: rd_word = status_w;
      is_ctrl:   rd_word[CTRL_EN] = en_q;
      is_thr:    rd_word = thr_rd;
      default:   rd_word = '0;
    endcase
  end

  always_ff @(posedge pclk or negedge prstb) begin
    if (!prstb) begin
      prdata_q <= '0;
      rd_vld_q <= 1'b0;
    end else if (setup) begin
      prdata_q <= rd_word;
      rd_vld_q <= is_data & ~empty;
    end
  end

  assign bus.req    = req_q;
  assign bus.prdata = prdata_q;

  assign unused_bits = ^{bus.paddr[31:4], bus.paddr[1:0],
                         bus.pwdata[31:3]};

endmodule

// File: tb/tb_tea_stream_fifo.sv
// Self-checking bench for tea_stream_fifo: core model on
// req/ack, APB driver, and a queue reference of stored words.
module tb_tea_stream_fifo;
  import tea_pkg::*;

  logic pclk;
  logic prstb;
`ifdef TEA_STREAM_FIFO_IRQ_EN
  logic irq;
`endif

  tea_stream_fifo_if bus();

  tea_stream_fifo #(.DEPTH(8)) dut (
    .pclk  (pclk),
    .prstb (prstb),
    .bus   (bus)
`ifdef TEA_STREAM_FIFO_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mq[$];
  logic [31:0] core_q[$];
  bit          m_udf = 0;
  bit          core_hold = 0;
  bit          busy = 0;
  int          core_ack_hold = 0;
  int          core_tmo = 0;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // core side: answer req, hold ack until req drops
  initial begin
    bit tmo;
    bus.ack   = 1'b0;
    bus.rdata = '0;
    forever begin
      @(posedge pclk);
      if (bus.req && !bus.ack && !core_hold && core_q.size() != 0) begin
        busy = 1;
        repeat ($urandom_range(0, 2)) @(posedge pclk);
        @(negedge pclk);
        bus.rdata = core_q.pop_front();
        bus.ack   = 1'b1;
        tmo = 1;
        for (int i = 0; i < 64; i++) begin
          @(negedge pclk);
          if (!bus.req) begin
            tmo = 0;
            break;
          end
        end
        if (tmo) core_tmo++;
        if (prstb && !tmo) mq.push_back(bus.rdata);
        repeat (core_ack_hold != 0 ? core_ack_hold
                                   : int'($urandom_range(0, 2)))
          @(negedge pclk);
        bus.ack = 1'b0;
        busy = 0;
      end
    end
  end

  function automatic logic [31:0] exp_status(int n, bit u);
    logic [31:0] r;
    r     = 32'(n);
    r[16] = (n == 0);
    r[17] = (n == 8);
    r[18] = u;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [1:0] r, input logic [31:0] d);
    @(negedge pclk);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b1;
    bus.paddr   = {28'h0, r, 2'b00};
    bus.pwdata  = d;
    @(negedge pclk);
    bus.penable = 1'b1;
    @(negedge pclk);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
  endtask

  task automatic apb_read(input logic [1:0] r, output logic [31:0] d);
    @(negedge pclk);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = {28'h0, r, 2'b00};
    @(negedge pclk);
    bus.penable = 1'b1;
    d = bus.prdata;
    @(negedge pclk);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
  endtask

  task automatic ctrl_write(input logic [31:0] d);
    apb_write(REG_CTRL, d);
    if (d[1]) mq.delete();
    if (d[2]) m_udf = 0;
  endtask

  task automatic read_data_chk(input string tag);
    logic [31:0] got;
    logic [31:0] exp;
    apb_read(REG_DATA, got);
    if (mq.size() != 0) exp = mq.pop_front();
    else begin
      exp   = '0;
      m_udf = 1;
    end
    check(tag, got, exp);
  endtask

  task automatic status_chk(input string tag);
    logic [31:0] v;
    apb_read(REG_STATUS, v);
    check(tag, v, exp_status(mq.size(), m_udf));
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge pclk);
      if (core_q.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
    end
    repeat (4) @(negedge pclk);
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_ack(input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge pclk);
      if (bus.ack) begin
        ok = 1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    logic [31:0] v;
    bit          seen;
    bit          ok;
    int          n;

    prstb       = 1'b1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = '0;
    bus.pwdata  = '0;
    #2 prstb = 1'b0;
    repeat (3) @(negedge pclk);
    check("rst_req", 32'(bus.req), 32'd0);
    check("rst_prdata", bus.prdata, 32'd0);
    prstb = 1'b1;
    status_chk("rst_status");
    apb_read(REG_CTRL, v);
    check("rst_ctrl", v, 32'd0);

    // single word
    ctrl_write(32'h1);
    core_q.push_back(32'hDEADBEEF);
    wait_idle("one_idle");
    status_chk("one_status");
    read_data_chk("one_data");
    status_chk("one_empty");

    // fill to full, then one pop lets the 9th in
    for (int i = 1; i <= 8; i++) core_q.push_back(32'(i));
    wait_idle("fill_idle");
    status_chk("fill_full");
    core_q.push_back(32'h9);
    seen = 0;
    repeat (6) begin
      @(negedge pclk);
      if (bus.req) seen = 1;
    end
    check("full_noreq", 32'(seen), 32'd0);
    read_data_chk("fill_head");
    seen = 0;
    repeat (3) begin
      @(negedge pclk);
      if (bus.req) seen = 1;
    end
    check("req_again", 32'(seen), 32'd1);
    wait_idle("ninth_idle");
    status_chk("ninth_full");
    for (int i = 0; i < 8; i++) read_data_chk("drain");
    status_chk("drain_empty");

    // underflow
    read_data_chk("udf_data");
    status_chk("udf_set");
    ctrl_write(32'h5);
    status_chk("udf_clr");
    apb_read(REG_CTRL, v);
    check("ctrl_en", v, 32'd1);

    // flush while REQ pending
    for (int i = 0; i < 4; i++) core_q.push_back($urandom);
    wait_idle("fl_idle");
    status_chk("fl_four");
    core_hold = 1;
    core_q.push_back(32'hCAFE0001);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge pclk);
      if (bus.req) begin
        ok = 1;
        break;
      end
    end
    check("fl_inreq", 32'(ok), 32'd1);
    ctrl_write(32'h3);
    status_chk("fl_zero");
    core_hold = 0;
    wait_idle("fl_idle2");
    status_chk("fl_one");
    read_data_chk("fl_data");

    // pop coinciding with push at level 3
    for (int i = 0; i < 3; i++) core_q.push_back($urandom);
    wait_idle("pp_idle");
    status_chk("pp_three");
    core_q.push_back($urandom);
    wait_ack("pp_ack");
    read_data_chk("pp_head");
    wait_idle("pp_idle2");
    status_chk("pp_level");
    for (int i = 0; i < 3; i++) read_data_chk("pp_order");

    // reset with ack high
    core_ack_hold = 20;
    core_q.push_back(32'hBAD00001);
    wait_ack("rh_ack");
    @(negedge pclk);
    prstb = 1'b0;
    mq.delete();
    m_udf = 0;
    #1;
    check("rh_req", 32'(bus.req), 32'd0);
    check("rh_prdata", bus.prdata, 32'd0);
`ifdef TEA_STREAM_FIFO_IRQ_EN
    check("rh_irq", 32'(irq), 32'd0);
`endif
    repeat (2) @(negedge pclk);
    prstb = 1'b1;
    core_q.push_back(32'h5EED0002);
    repeat (3) @(negedge pclk);
    ctrl_write(32'h1);
    status_chk("rh_level0");
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge pclk);
      if (!bus.ack) break;
      if (bus.req) seen = 1;
    end
    check("rh_noreq", 32'(seen), 32'd0);
    core_ack_hold = 0;
    wait_idle("rh_idle");
    status_chk("rh_one");
    read_data_chk("rh_data");

`ifdef TEA_STREAM_FIFO_IRQ_EN
    apb_write(REG_THR, 32'h2);
    apb_read(REG_THR, v);
    check("thr_rd", v, 32'd2);
    core_q.push_back($urandom);
    wait_idle("irq_idle1");
    check("irq_lo", 32'(irq), 32'd0);
    core_q.push_back($urandom);
    wait_idle("irq_idle2");
    check("irq_hi", 32'(irq), 32'd1);
    read_data_chk("irq_pop");
    repeat (2) @(negedge pclk);
    check("irq_drop", 32'(irq), 32'd0);
    read_data_chk("irq_drain");
`else
    apb_write(REG_THR, 32'h5);
    apb_read(REG_THR, v);
    check("thr_zero", v, 32'd0);
`endif

    // random traffic against the queue model
    n = 24;
    for (int i = 0; i < n; i++) core_q.push_back($urandom);
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      if (core_q.size() == 0 && !busy && mq.size() == 0) begin
        ok = 1;
        break;
      end
      if (mq.size() != 0 && $urandom_range(0, 1) == 1)
        read_data_chk("rnd_data");
      else
        repeat ($urandom_range(1, 4)) @(negedge pclk);
    end
    check("rnd_done", 32'(ok), 32'd1);
    repeat (4) @(negedge pclk);
    status_chk("rnd_empty");
    check("core_tmo", 32'(core_tmo), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tea_stream_fifo.md
Name: tea_stream_fifo

Overview:
- Downstream collector for the tinyenc/tinydec cores.
- Pulls 32-bit result words over the core's 4-phase req/ack handshake and buffers them in a FIFO.
- Software drains the FIFO over the APB bus already used for core configuration.
- Runs entirely on the APB clock; the core's ack is synchronised internally.

Parameters:
- DEPTH, 8, number of 32-bit FIFO entries; must be a power of two, minimum 2.
- AW, $clog2(DEPTH), FIFO pointer width; the level counter is AW+1 bits.

Ports:
- pclk  input  1  block clock.
- prstb  input  1  asynchronous active-low reset.
- req  output  1  request to core; high means the FIFO has room for one word.
- ack  input  1  core acknowledge, asynchronous to pclk; rdata is stable while ack is high.
- rdata  input  32  core result word.
- psel  input  1  APB select.
- penable  input  1  APB enable.
- pwrite  input  1  APB write.
- paddr  input  32  APB address; only bits [3:2] are decoded.
- pwdata  input  32  APB write data.
- prdata  output  32  APB read data.
- irq  output  1  level interrupt; present only with the optional feature.

Behaviour:
- Reset (prstb low, asynchronous) clears:
  - req, prdata, FIFO pointers, level, CTRL and sticky flags to 0;
  - the ack synchroniser to 0;
  - FSM to IDLE.
- ack passes through a 2-flop synchroniser (ack_s), adding 2 cycles of latency.
- Upstream FSM:
  - IDLE: req=0. Go to REQ when CTRL.en=1, level<DEPTH and ack_s=0.
  - REQ: req=1. When ack_s=1, push rdata into the FIFO and go to DONE.
  - DONE: req=0. Wait for ack_s=0, then go to IDLE.
- The slot is reserved on entering REQ. Only pops can occur meanwhile, so the FIFO never overflows.
- Clearing CTRL.en mid-handshake does not abort it; the FSM completes the transaction and the word is stored.
- APB transfers complete in one access cycle (psel&penable); there is no wait state.
- Register map (paddr[3:2]):
  - 0 DATA (RO): read returns the head word and pops it. Read when empty returns 0, does not move pointers, and sets STATUS.udf.
  - 1 STATUS (RO): [AW:0] level, [16] empty, [17] full, [18] udf (sticky, write-1-to-clear via CTRL[2]).
  - 2 CTRL (RW): [0] en, [1] flush (self-clearing, reads 0), [2] udf_clr (self-clearing).
  - 3 THR (RW): irq threshold; reads 0 and is not writable without the optional feature.
- prdata is registered. It updates on the setup cycle (psel&~penable&~pwrite) so it is valid during the access cycle. The DATA pop occurs in the access cycle.
- Simultaneous push and pop: level unchanged, both pointers advance.
- Push into an empty FIFO: the word is readable through DATA starting two cycles later.
- Flush: pointers and level go to 0 next cycle.
  - A push in the same cycle as flush is discarded.
  - An in-flight handshake still completes; a word pushed after the flush is kept.
- Pointers wrap modulo DEPTH; full = (level==DEPTH).

Optional Feature:
- Macro: TEA_STREAM_FIFO_IRQ_EN.
- Defined:
  - THR register is implemented (AW+1 bits, reset 0).
  - irq is registered, high while level>=THR and THR!=0.
  - irq deasserts in the cycle after the pop that drops level below THR.
- Undefined: THR reads 0, irq port is absent, no extra flops.

Decomposition:
- Package tea_pkg holds:
  - register offset constants DATA/STATUS/CTRL/THR;
  - STATUS/CTRL bit-index constants;
  - FSM state enum (IDLE, REQ, DONE).
- Sub-module tea_sync2: generic 2-flop synchroniser with pclk/prstb, used for ack.

Test Plan:
- Reset then CTRL=0x1; a core model answers req with rdata=0xDEADBEEF -> STATUS level=1, empty=0; DATA read returns 0xDEADBEEF; level=0, empty=1.
- DEPTH=8; push 8 words 0x1..0x8 without reading -> full=1 and req stays 0. Read one word -> 0x1; req reasserts within 3 cycles; 9th word 0x9 is accepted. Full drain returns 0x2..0x9 in order.
- Read DATA when empty -> prdata=0, STATUS.udf=1, level stays 0. Write CTRL=0x5 -> udf=0, en=1.
- Pop in the same cycle a push lands with level=3 -> level stays 3, order preserved.
- Flush while FSM is in REQ with 4 words queued -> level=0. The pending word 0xCAFE0001 arrives and is kept: level=1, DATA reads 0xCAFE0001.
- Assert prstb low mid-handshake with ack high -> req=0, level=0, irq=0 immediately. After release, no spurious push until ack has dropped and been re-raised. With TEA_STREAM_FIFO_IRQ_EN: THR=2 gives irq=1 after the second push and irq=0 after one read.
